// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, reset PC, fetch FSM states and FIFO entry type
// Contents:
//   WORD_W           instruction / address width
//   DEFAULT_RESET_PC PC loaded on reset unless overridden
//   fetch_state_t    fetch FSM states
//   fetch_entry_t    prefetch FIFO entry {instr, pc}
//   align_word()     clears the byte-offset bits of an address
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {instr, pc} entries with flush
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write one entry
//   pop               discard the head entry
//   flush             empty the FIFO; wins over push and pop in the same cycle
//   head              entry at the head (driven from storage registers)
//   count, full, empty occupancy
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, imem req/ack, prefetch FIFO, redirect
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_req, imem_addr        word read request to instruction memory
//   imem_ack, imem_rdata       request completion and returned word
//   instr_valid, instr_ready   decode handshake on the FIFO head
//   instr, instr_pc            FIFO head word and its address
//   redirect, redirect_pc      branch/jump restart target
// Build option: FETCH_FAST_ISSUE_EN issues the next request in the ack cycle.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_n;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_addr_n;
    logic              discard;
    logic              discard_n;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] pc_inc;

    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;

    assign target      = align_word(redirect_pc);
    assign pc_inc      = pc + 32'd4;
    assign imem_req    = (state == FS_WAIT);
    // imem_addr comes from its own register so it stays put while a
    // redirect rewrites pc under an outstanding request.
    assign imem_addr   = req_addr;
    assign instr_valid = !fifo_empty && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    assign push_data.instr = imem_rdata;
    assign push_data.pc    = req_addr;

`ifdef FETCH_FAST_ISSUE_EN
    logic [CNT_W-1:0] fill_after;
    logic             fast_room;
    // Occupancy once this cycle's push and any pop have landed.
    assign fill_after = count + CNT_W'(1) - CNT_W'(pop);
    assign fast_room  = (fill_after < CNT_W'(DEPTH));
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FS_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            discard  <= discard_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        discard_n  = discard;
        push       = 1'b0;

        if (redirect) begin
            pc_n = target;
            if (state == FS_WAIT && !imem_ack) begin
                // Request still in flight: let it finish, then drop its data.
                discard_n = 1'b1;
            end else begin
                // Nothing outstanding after this edge and the FIFO is being
                // flushed, so the target can be requested right away.
                discard_n  = 1'b0;
                state_n    = FS_WAIT;
                req_addr_n = target;
            end
        end else begin
            case (state)
                FS_IDLE: begin
                    if (!fifo_full) begin
                        state_n    = FS_WAIT;
                        req_addr_n = pc;
                    end
                end
                FS_WAIT: begin
                    if (imem_ack) begin
                        if (discard) begin
                            // FIFO was flushed by the redirect, so there is room
                            // to go straight to the redirect target.
                            discard_n  = 1'b0;
                            state_n    = FS_WAIT;
                            req_addr_n = pc;
                        end else begin
                            push       = 1'b1;
                            pc_n       = pc_inc;
                            req_addr_n = pc_inc;
`ifdef FETCH_FAST_ISSUE_EN
                            state_n    = fast_room ? FS_WAIT : FS_IDLE;
`else
                            state_n    = FS_IDLE;
`endif
                        end
                    end
                end
                default: state_n = FS_IDLE;
            endcase
        end
    end

endmodule
